vgaram_ctrl: RTL

VGARAM_CTRL -- requirements
Module: vgaram_ctrl

---
 rtl/vgaram_ctrl_pkg.sv | 16 +
 rtl/vgaram_ctrl_wr_fifo.sv | 58 +++++
 rtl/vgaram_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vgaram_ctrl_pkg.sv
// Shared defaults and state encoding for the video RAM arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vgaram_ctrl_pkg;

   localparam int          ADDR_W_DEF   = 16;
   localparam int          DATA_W_DEF   = 8;
   localparam logic [15:0] CLR_LAST_DEF = 16'h7FFF;

   // Controller states: IDLE drains CPU writes, CLEAR fills the frame.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/vgaram_ctrl_wr_fifo.sv
// Purpose: synchronous FIFO buffering CPU writes; head word visible on pop_data.
// Latency: a pushed word is visible at the head on the following cycle.
// Backpressure: push ignored when full, pop ignored when empty; full is registered.
// Ports: clk/reset; push + push_data in; pop in, pop_data out (head);
//        full, empty, count status from the registered occupancy.
module wr_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/vgaram_ctrl.sv
// Purpose: single-port video RAM arbiter: display read > clear fill > CPU write drain.
// Latency: RAM control combinational; disp_valid/disp_data one cycle after disp_rd_en.
// Backpressure: cpu_wr_ready low while the write buffer is full; display reads stall fill/drain.
// Ports: clk/reset; cpu_wr_* write request; clr_start/clr_color fill command;
//        busy status; disp_* scan-out read; ram_* single-port RAM interface.
module vgaram_ctrl
   import vgaram_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(CLR_LAST_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_wr_valid,
   output logic              cpu_wr_ready,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   input  logic              clr_start,
   input  logic [2:0]        clr_color,
   output logic              busy,
   input  logic              disp_rd_en,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int FW = ADDR_W + DATA_W;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] clr_cnt_nx;
   logic [DATA_W-1:0] clr_col;
   logic              load_col;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              fifo_push;
   logic              fifo_pop;
   logic [FW-1:0]     fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign cpu_wr_ready           = ~fifo_full;
   assign fifo_push              = cpu_wr_valid & cpu_wr_ready;
   assign {head_addr, head_data} = fifo_head;
   assign busy                   = (state == CLEAR) | (fifo_count != '0);

   wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_wr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({cpu_wr_addr, cpu_wr_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Port ownership: a display read always wins; otherwise the clear or the
   // FIFO head gets the write slot. With nothing scheduled the address and
   // data hold their last driven values.
   always_comb begin
      state_nx   = state;
      clr_cnt_nx = clr_cnt;
      load_col   = 1'b0;
      fifo_pop   = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr_q;
      ram_wdata  = wdata_q;

      if (disp_rd_en) ram_addr = disp_addr;

      case (state)
         IDLE: begin
            // A fill command preempts draining so buffered writes land on top of it.
            if (clr_start) begin
               state_nx   = CLEAR;
               clr_cnt_nx = '0;
               load_col   = 1'b1;
            end else if (!fifo_empty && !disp_rd_en) begin
               fifo_pop  = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = head_addr;
               ram_wdata = head_data;
            end
         end
         CLEAR: begin
            // A display read stalls the counter, so no address is skipped.
            if (!disp_rd_en) begin
               ram_we    = 1'b1;
               ram_addr  = clr_cnt;
               ram_wdata = clr_col;
               if (clr_cnt == CLR_LAST) begin
                  state_nx   = IDLE;
                  clr_cnt_nx = '0;
               end else begin
                  clr_cnt_nx = clr_cnt + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // Reset aborts everything: no RAM write and no buffer pop in that cycle.
      if (reset) begin
         ram_we   = 1'b0;
         fifo_pop = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clr_cnt    <= '0;
         clr_col    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         disp_valid <= 1'b0;
         disp_data  <= '0;
      end else begin
         clr_cnt    <= clr_cnt_nx;
         if (load_col) clr_col <= DATA_W'(clr_color);
         addr_q     <= ram_addr;
         wdata_q    <= ram_wdata;
         disp_valid <= disp_rd_en;
         if (disp_rd_en) disp_data <= ram_rdata;
      end
   end

endmodule
